ncl_word_sync_receiver: RTL and testbench
=========================================

// Module: ncl_word_sync_receiver
// PURPOSE
//  Clocked receiver for the dual-rail sum word produced by the fullword NCL counter ring.
//  Samples WIDTH dual-rail bits and detects full-word DATA and full-word NULL.
//  Captures each DATA wavefront into a binary register and presents it on a valid/ready port.
//  Drives the ring's sumcomp completion input, which closes the four-phase handshake.
//  Sits at the NCL-to-clocked boundary, downstream of the 32 counter slices.
// PARAMETERS
//  WIDTH        32  number of dual-rail bits in the word
//  SYNC_STAGES  2   flops per rail in the input synchronizer (>=2)
//  CHECK_INC    1   1: flag any captured value that is not prev+1 mod 2^WIDTH
// PORTS
//  clk          in   1        single clock
//  rst_n        in   1        asynchronous, active-low reset
//  dr_sum       in   2*WIDTH  bit i = {dr_sum[2i+1]=TRUE rail, dr_sum[2i]=FALSE rail}
//  sumcomp      out  1        completion to ring: 1 = DATA taken, send NULL; 0 = send DATA
//  out_data     out  WIDTH    captured binary word
//  out_valid    out  1        out_data holds an unconsumed word
//  out_ready    in   1        consumer accepts out_data when out_valid&out_ready
//  err_clr      in   1        synchronous clear of both sticky error flags
//  err_illegal  out  1        sticky: some synced bit had both rails high
//  err_seq      out  1        sticky: increment check failed (CHECK_INC=1 only)
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - sumcomp=0, out_valid=0, out_data=0, errors=0.
//   - Sync flops=0, state=WAIT_DATA, first_word=1.
//  Synchronizer: each rail passes through SYNC_STAGES flops. This is safe because NCL rails
//   are monotonic between handshakes, so no multi-bit skew hazard remains once the word is complete.
//  Decode on synced rails
//   - data_cmpl = every bit has exactly one rail high.
//   - null_cmpl = all 2*WIDTH rails low.
//   - illegal   = any bit has both rails high.
//  FSM
//   WAIT_DATA
//    - Condition: data_cmpl & (!out_valid | out_ready).
//    - Action: out_data<=TRUE rails, out_valid<=1, sumcomp<=1, go to WAIT_NULL.
//    - data_cmpl with the slot full and no out_ready: stall in WAIT_DATA with sumcomp=0.
//      The ring is back-pressured because no ack is given.
//   WAIT_NULL
//    - null_cmpl: sumcomp<=0, go to WAIT_DATA.
//    - Partial NULL: hold.
//  Latency
//   - Input word complete at edge t: out_valid and sumcomp high at edge t+SYNC_STAGES+1.
//   - NULL complete at edge t: sumcomp low at edge t+SYNC_STAGES+1.
//  Output handshake
//   - out_valid clears on the accept edge unless a capture occurs on the same edge.
//   - Simultaneous accept and capture: the new word replaces the old one and out_valid stays 1.
//   - out_data is stable while out_valid=1 and out_ready=0.
//  Errors
//   - illegal in any state sets err_illegal. That word is never data_cmpl, so the FSM holds.
//   - CHECK_INC=1, on a capture with first_word=0 and value != prev+1 (mod 2^WIDTH): set err_seq.
//   - The wrap 2^WIDTH-1 -> 0 is legal.
//   - first_word clears on the first capture.
//   - err_clr clears both flags. If err_clr and a new error occur on the same edge, the set wins.
//  Mid-operation reset returns to WAIT_DATA with sumcomp=0. The ring's own init re-seeds its
//   wavefront, so no partial word is ever captured.
// STRUCTURE
//  - ncl_pkg: the dual-rail rail index constants (RAIL_F=0, RAIL_T=1) and the FSM state
//    enum {WAIT_DATA, WAIT_NULL}.
//  - One sub-module, ncl_dr_sync: a SYNC_STAGES-deep reset-to-0 synchronizer vector,
//    instantiated once over all 2*WIDTH rails.
//  - Completeness trees, FSM, capture register and checker live in the top module.
// TESTING (bench models the ring as a 4-phase dual-rail source that honours sumcomp)
//  1 Reset, then drive word 0x00000005 (all rails settled)
//    -> out_data=0x00000005, out_valid=1 and sumcomp=1 exactly 3 edges later.
//  2 Drive NULL with 8 bits going low one per cycle
//    -> sumcomp holds 1 until the last rail is low, then falls 3 edges later.
//  3 Drive 0xFFFFFFFF then 0x00000000 with out_ready=1
//    -> both captured, err_seq=0. Then drive 0x00000002 -> err_seq=1.
//  4 Hold out_ready=0 after a capture, then present the next DATA
//    -> sumcomp stays 0 and out_data unchanged; raise out_ready -> capture 1 edge later.
//  5 Force bit 7 with both rails high -> err_illegal=1, no capture.
//    Pulse err_clr -> flag clears while the fault is removed.
//  6 Assert rst_n=0 in WAIT_NULL mid-NULL
//    -> sumcomp=0, out_valid=0 asynchronously. The next full word captures with err_seq=0.

Source files
------------

// File: rtl/ncl_pkg.sv
// Shared constants for the NCL sum-word receiver: dual-rail rail indices and receiver FSM states.
package ncl_pkg;

   localparam int RAIL_F = 0;
   localparam int RAIL_T = 1;

   typedef enum logic {
      WAIT_DATA = 1'b0,
      WAIT_NULL = 1'b1
   } rx_state_e;

endpackage

// File: rtl/ncl_dr_sync.sv
// Multi-stage reset-to-0 synchronizer applied independently to every rail of a dual-rail vector.
module ncl_dr_sync #(
   parameter int N      = 64,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   logic [STAGES-1:0][N-1:0] sync_q;
   logic [STAGES-1:0][N-1:0] sync_d;

   always_comb begin
      sync_d[0] = d;
      for (int s = 1; s < STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ncl_word_sync_receiver.sv
// Clocked receiver for the NCL counter ring's dual-rail sum word: completion detection,
// four-phase ack (sumcomp), capture onto a valid/ready port and sticky error checking.
//
// state     | meaning
// WAIT_DATA | sumcomp=0, waiting for a complete DATA word and a free output slot
// WAIT_NULL | sumcomp=1, word taken, waiting for every rail to return low
module ncl_word_sync_receiver
   import ncl_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter bit CHECK_INC   = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2*WIDTH-1:0] dr_sum,
   output logic               sumcomp,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic               err_clr,
   output logic               err_illegal,
   output logic               err_seq
);

   logic [2*WIDTH-1:0] rails_s;
   logic [WIDTH-1:0]   rail_t;
   logic [WIDTH-1:0]   rail_f;
   logic               data_cmpl;
   logic               null_cmpl;
   logic               illegal;
   logic               capture;
   logic               seq_bad;

   rx_state_e          state_q, state_d;
   logic               sumcomp_q, sumcomp_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               first_word_q, first_word_d;
   logic               err_illegal_q, err_illegal_d;
   logic               err_seq_q, err_seq_d;

   ncl_dr_sync #(
      .N      (2*WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (dr_sum),
      .q     (rails_s)
   );

   always_comb begin
      rail_t = '0;
      rail_f = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rail_t[i] = rails_s[2*i+RAIL_T];
         rail_f[i] = rails_s[2*i+RAIL_F];
      end
   end

   assign data_cmpl = &(rail_t ^ rail_f);
   assign null_cmpl = ~|rails_s;
   assign illegal   = |(rail_t & rail_f);

   // A full slot without out_ready withholds the ack, back-pressuring the ring.
   assign capture = (state_q == WAIT_DATA) && data_cmpl && (!out_valid_q || out_ready);

   // out_data_q always holds the last captured word, so it doubles as the previous value.
   assign seq_bad = CHECK_INC && capture && !first_word_q &&
                    (rail_t != (out_data_q + WIDTH'(1)));

   always_comb begin
      state_d   = state_q;
      sumcomp_d = sumcomp_q;
      case (state_q)
         WAIT_DATA: begin
            if (capture) begin
               state_d   = WAIT_NULL;
               sumcomp_d = 1'b1;
            end
         end
         WAIT_NULL: begin
            if (null_cmpl) begin
               state_d   = WAIT_DATA;
               sumcomp_d = 1'b0;
            end
         end
         default: begin
            state_d   = WAIT_DATA;
            sumcomp_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      first_word_d  = first_word_q;
      if (capture) begin
         out_data_d   = rail_t;
         out_valid_d  = 1'b1;
         first_word_d = 1'b0;
      end else if (out_valid_q && out_ready) begin
         out_valid_d  = 1'b0;
      end
      err_illegal_d = illegal | (err_illegal_q & ~err_clr);
      err_seq_d     = seq_bad | (err_seq_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= WAIT_DATA;
         sumcomp_q     <= 1'b0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         first_word_q  <= 1'b1;
         err_illegal_q <= 1'b0;
         err_seq_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         sumcomp_q     <= sumcomp_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         first_word_q  <= first_word_d;
         err_illegal_q <= err_illegal_d;
         err_seq_q     <= err_seq_d;
      end
   end

   assign sumcomp     = sumcomp_q;
   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign err_illegal = err_illegal_q;
   assign err_seq     = err_seq_q;

endmodule

// File: tb/tb_ncl_word_sync_receiver.sv
// Directed bench for ncl_word_sync_receiver: a 4-phase dual-rail source that honours sumcomp.
module tb_ncl_word_sync_receiver;

   logic        clk;
   logic        rst_n;
   logic [63:0] dr_sum;
   logic        sumcomp;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        err_clr;
   logic        err_illegal;
   logic        err_seq;

   int n_chk  = 0;
   int n_pass = 0;

   ncl_word_sync_receiver #(
      .WIDTH       (32),
      .SYNC_STAGES (2),
      .CHECK_INC   (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .dr_sum      (dr_sum),
      .sumcomp     (sumcomp),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .err_clr     (err_clr),
      .err_illegal (err_illegal),
      .err_seq     (err_seq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] enc(input logic [31:0] w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[2*i+1] = w[i];
         r[2*i]   = ~w[i];
      end
      return r;
   endfunction

   task automatic data_phase(input string tag, input logic [31:0] w);
      dr_sum = enc(w);
      for (int k = 0; k < 20; k++) begin
         tick();
         if (sumcomp) break;
      end
      chk({tag, " ack"}, {63'd0, sumcomp}, 64'd1);
      chk({tag, " data"}, {32'd0, out_data}, {32'd0, w});
   endtask

   task automatic null_phase(input string tag);
      dr_sum = '0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (!sumcomp) break;
      end
      chk({tag, " null"}, {63'd0, sumcomp}, 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      dr_sum    = '0;
      out_ready = 1'b0;
      err_clr   = 1'b0;
      #23;
      chk("rst sumcomp", {63'd0, sumcomp}, 64'd0);
      chk("rst valid", {63'd0, out_valid}, 64'd0);
      chk("rst data", {32'd0, out_data}, 64'd0);
      chk("rst errs", {62'd0, err_illegal, err_seq}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // 1: capture latency of three edges
      dr_sum = enc(32'h0000_0005);
      tick();
      tick();
      chk("lat valid early", {63'd0, out_valid}, 64'd0);
      tick();
      chk("lat valid", {63'd0, out_valid}, 64'd1);
      chk("lat sumcomp", {63'd0, sumcomp}, 64'd1);
      chk("lat data", {32'd0, out_data}, 64'h5);

      // 2: partial NULL holds the ack until the last rail falls
      dr_sum[63:16] = '0;
      tick();
      for (int i = 0; i < 7; i++) begin
         dr_sum[2*i+:2] = 2'b00;
         tick();
         chk("partial null hold", {63'd0, sumcomp}, 64'd1);
      end
      dr_sum[15:14] = 2'b00;
      tick();
      tick();
      chk("null hold late", {63'd0, sumcomp}, 64'd1);
      tick();
      chk("null release", {63'd0, sumcomp}, 64'd0);
      chk("null keeps word", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h5});

      // 3: increment check including the wrap
      out_ready = 1'b1;
      data_phase("ffff", 32'hFFFF_FFFF);
      chk("5->ffff seq", {63'd0, err_seq}, 64'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr seq", {63'd0, err_seq}, 64'd0);
      null_phase("ffff");
      data_phase("wrap", 32'h0000_0000);
      chk("wrap seq", {63'd0, err_seq}, 64'd0);
      null_phase("wrap");
      data_phase("skip", 32'h0000_0002);
      chk("skip seq", {63'd0, err_seq}, 64'd1);
      null_phase("skip");
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // 4: back-pressure with a full slot
      out_ready = 1'b0;
      data_phase("bp3", 32'h0000_0003);
      null_phase("bp3");
      dr_sum = enc(32'h0000_0004);
      for (int k = 0; k < 6; k++) tick();
      chk("bp sumcomp", {63'd0, sumcomp}, 64'd0);
      chk("bp hold", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h3});
      out_ready = 1'b1;
      tick();
      chk("bp release", {30'd0, sumcomp, out_valid, out_data}, {30'd0, 2'b11, 32'h4});
      chk("bp seq", {63'd0, err_seq}, 64'd0);
      null_phase("bp4");

      // 5: illegal bit 7, clear only wins once the fault is gone
      dr_sum = enc(32'h0000_0005);
      dr_sum[15:14] = 2'b11;
      for (int k = 0; k < 4; k++) tick();
      chk("illegal flag", {63'd0, err_illegal}, 64'd1);
      chk("illegal no ack", {63'd0, sumcomp}, 64'd0);
      chk("illegal no capture", {32'd0, out_data}, 64'h4);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("illegal set wins", {63'd0, err_illegal}, 64'd1);
      dr_sum = '0;
      for (int k = 0; k < 3; k++) tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("illegal clear", {63'd0, err_illegal}, 64'd0);

      // 6: async reset mid-NULL, then a fresh first word
      data_phase("pre rst", 32'h0000_0005);
      chk("pre rst seq", {63'd0, err_seq}, 64'd0);
      dr_sum[63:32] = '0;
      for (int k = 0; k < 3; k++) tick();
      chk("mid null ack", {63'd0, sumcomp}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst", {62'd0, sumcomp, out_valid}, 64'd0);
      dr_sum = '0;
      for (int k = 0; k < 3; k++) tick();
      rst_n = 1'b1;
      tick();
      data_phase("post rst", 32'h0000_0009);
      chk("post rst errs", {62'd0, err_illegal, err_seq}, 64'd0);
      null_phase("post rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
